// File: rtl/instr_prefetch_unit.sv
// Decoupled instruction fetch front end: issues in-order fetches, buffers (pc, instr) pairs
// in a small FIFO and discards in-flight fetches made stale by a branch redirect.
module instr_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0,
    localparam int         CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect,
    input  logic [63:0]   redirect_pc,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [63:0]   imem_req_addr,
    input  logic          imem_resp_valid,
    input  logic [31:0]   imem_resp_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic [CW-1:0] occupancy
);

    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          DW  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] live_q, live_d;
    logic [DW-1:0] drop_q, drop_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [63:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [CW:0]   credit_sum;
    logic          req_fire;
    logic          outstanding;
    logic          resp_drop;
    logic          resp_keep;
    logic          pop;
    logic [63:0]   target_pc;
    logic          unused_lsbs;

    assign target_pc   = {redirect_pc[63:2], 2'b00};
    assign unused_lsbs = ^redirect_pc[1:0];

    // Credits cover both buffered entries and kept in-flight fetches, so a push never finds the FIFO full.
    assign credit_sum     = {1'b0, count_q} + {1'b0, live_q};
    assign imem_req_valid = !rst && !redirect && (credit_sum < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign outstanding = (drop_q != '0) || (live_q != '0);
    assign resp_drop   = imem_resp_valid && (drop_q != '0);
    assign resp_keep   = imem_resp_valid && (drop_q == '0) && (live_q != '0) && !redirect;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q] : 64'h0;
    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : NOP;
    assign occupancy = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        live_d     = live_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            // Every fetch still owed by memory becomes a drop; a response arriving now retires one of them.
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            drop_d     = drop_q + DW'(live_q) - DW'(imem_resp_valid && outstanding);
            live_d     = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            if (resp_drop) begin
                drop_d = drop_q - DW'(1);
            end
            if (resp_keep) begin
                resp_pc_d = resp_pc_q + 64'd4;
            end
            live_d   = live_q + CW'(req_fire) - CW'(resp_keep);
            wr_ptr_d = wr_ptr_q + PW'(resp_keep);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            count_d  = count_q + CW'(resp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resp_keep) begin
            pc_mem[wr_ptr_q]    <= resp_pc_q;
            instr_mem[wr_ptr_q] <= imem_resp_data;
        end
    end

    resp_has_owner: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> outstanding)
        else $error("instr_prefetch_unit: response with no outstanding request");

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: in-order memory model with configurable latency and a
// scoreboard of expected (pc, instr) entries, invalidated by epoch on redirect/reset.
module tb_instr_prefetch_unit;
    localparam int          DEPTH  = 4;
    localparam int          CW     = $clog2(DEPTH + 1);
    localparam logic [63:0] RST_PC = 64'h0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          redirect = 1'b0;
    logic [63:0]   redirect_pc = 64'h0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [63:0]   imem_req_addr;
    logic          imem_resp_valid = 1'b0;
    logic [31:0]   imem_resp_data = 32'h0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_pc;
    logic [31:0]   out_instr;
    logic [CW-1:0] occupancy;

    always #5 clk = ~clk;

    instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .occupancy(occupancy)
    );

    typedef struct {logic [63:0] addr; logic [63:0] pc; int epoch; int due;} req_t;
    typedef struct {logic [63:0] pc; logic [31:0] instr;} ent_t;

    req_t pend[$];
    ent_t sb[$];

    int n_vec = 0, n_miss = 0;
    int cyc = 0, epoch = 0, lat = 1, n_acc = 0, n_drop = 0, n_pop = 0;
    logic [63:0] exp_addr = RST_PC;
    bit chk_en = 0;
    bit rst_c = 1, redir_c = 0, rready_c = 0, oready_c = 0;
    logic [63:0] redir_pc_c = 64'h0;
    bit last_req_valid = 0, last_resp_dropped = 0;

    function automatic logic [31:0] mem_word(logic [63:0] a);
        return {a[17:2], ~a[17:2]} ^ 32'h0000_0013;
    endfunction

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d: got %h want %h", tag, cyc, got, exp);
        end
    endtask

    // One clock: check the state left by the previous edge, drive inputs, then advance the model.
    task automatic cycle();
        req_t r, nr;
        ent_t e;
        bit rv;
        @(negedge clk);
        if (chk_en) begin
            check_eq("out_valid", out_valid, sb.size() != 0);
            check_eq("occupancy", occupancy, sb.size());
            if (sb.size() != 0) begin
                check_eq("out_pc", out_pc, sb[0].pc);
                check_eq("out_instr", out_instr, sb[0].instr);
            end else begin
                check_eq("out_instr_nop", out_instr, 32'h0000_0013);
                check_eq("out_pc_idle", out_pc, 64'h0);
            end
        end
        rst = rst_c; redirect = redir_c; redirect_pc = redir_pc_c;
        imem_req_ready = rready_c; out_ready = oready_c;
        rv = 0;
        if (!rst_c && pend.size() != 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            rv = 1;
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(r.addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
        #1;
        last_req_valid    = imem_req_valid;
        last_resp_dropped = 0;
        if (rst_c) begin
            if (chk_en) check_eq("req_valid_in_rst", imem_req_valid, 1'b0);
            sb.delete(); pend.delete();
            exp_addr = RST_PC;
            epoch++;
        end else begin
            if (sb.size() != 0 && oready_c) begin
                void'(sb.pop_front());
                n_pop++;
            end
            if (redir_c) begin
                check_eq("req_valid_in_redirect", imem_req_valid, 1'b0);
                epoch++;
                sb.delete();
                exp_addr = {redir_pc_c[63:2], 2'b00};
            end
            if (rv) begin
                if (r.epoch == epoch) begin
                    e.pc = r.pc; e.instr = mem_word(r.pc);
                    sb.push_back(e);
                end else begin
                    n_drop++;
                    last_resp_dropped = 1;
                end
            end
            if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_addr);
            if (imem_req_valid && rready_c) begin
                nr.addr = imem_req_addr; nr.pc = exp_addr; nr.epoch = epoch; nr.due = cyc + lat;
                pend.push_back(nr);
                exp_addr += 64'd4;
                n_acc++;
            end
        end
        cyc++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_c = 1; redir_c = 0; rready_c = 0; oready_c = 0;
        run(2);
        rst_c = 0; n_acc = 0; n_drop = 0; n_pop = 0;
    endtask

    task automatic fill_to(int n);
        int k;
        k = 0;
        while (sb.size() != n && k < 50) begin cycle(); k++; end
        if (k >= 50) check_eq("fill_timeout", 0, 1);
    endtask

    task automatic wait_out(int budget);
        int k;
        k = 0;
        while (!out_valid && k < budget) begin cycle(); k++; end
        if (k >= budget) check_eq("out_timeout", 0, 1);
    endtask

    int acc0;

    initial begin
        // Reset state
        cycle();
        chk_en = 1;
        run(2);

        // Reset stream, latency 1
        lat = 1; rst_c = 0; rready_c = 1; oready_c = 1;
        cycle();
        check_eq("first_req_valid", last_req_valid, 1'b1);
        run(20);
        check_eq("stream_accepts", n_acc, 21);
        check_eq("stream_pops", n_pop, 19);

        // Backpressure: out_ready low fills exactly DEPTH entries
        do_reset();
        rready_c = 1; oready_c = 0;
        run(10);
        check_eq("bp_accepts", n_acc, DEPTH);
        check_eq("bp_req_valid", last_req_valid, 1'b0);
        check_eq("bp_occupancy", occupancy, DEPTH);
        oready_c = 1;
        run(10);
        check_eq("bp_resume", n_acc > DEPTH, 1'b1);

        // Memory stall at 0x20
        do_reset();
        redir_c = 1; redir_pc_c = 64'h20; rready_c = 0; oready_c = 1;
        cycle();
        redir_c = 0;
        acc0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("stall_addr", imem_req_addr, 64'h20);
        end
        check_eq("stall_no_accept", n_acc, acc0);
        rready_c = 1;
        cycle();
        check_eq("stall_one_accept", n_acc, acc0 + 1);
        run(6);

        // Redirect with two fetches in flight, latency 3
        do_reset();
        lat = 3; rready_c = 1; oready_c = 1;
        run(2);
        rready_c = 0;
        redir_c = 1; redir_pc_c = 64'h1002;
        cycle();
        redir_c = 0; rready_c = 1;
        cycle();
        check_eq("redir_first_addr", pend[pend.size()-1].addr, 64'h1000);
        wait_out(20);
        check_eq("redir_first_out_pc", out_pc, 64'h1000);
        check_eq("redir_drops", n_drop, 2);
        run(8);

        // Redirect, response and pop in one cycle at occupancy 2
        do_reset();
        lat = 1; rready_c = 1; oready_c = 0;
        fill_to(2);
        redir_c = 1; redir_pc_c = 64'h200; oready_c = 1;
        cycle();
        check_eq("t5_resp_dropped", last_resp_dropped, 1'b1);
        redir_c = 0;
        cycle();
        check_eq("t5_occupancy", occupancy, 0);
        wait_out(10);
        check_eq("t5_first_pc", out_pc, 64'h200);
        run(10);

        // Reset mid-stream at occupancy 3
        do_reset();
        lat = 1; rready_c = 1; oready_c = 0;
        fill_to(3);
        rst_c = 1;
        cycle();
        @(posedge clk); #1;
        check_eq("mid_rst_valid", out_valid, 1'b0);
        check_eq("mid_rst_instr", out_instr, 32'h0000_0013);
        check_eq("mid_rst_occ", occupancy, 0);
        rst_c = 0; oready_c = 1;
        cycle();
        check_eq("mid_rst_req_valid", last_req_valid, 1'b1);
        check_eq("mid_rst_req_addr", imem_req_addr, RST_PC);
        run(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
